// File: rtl/word_tokenizer_pkg.sv
// Shared types and constants for the word tokenizer: token codes, FSM states,
// ASCII constants and keyword lookup helpers.
package word_tokenizer_pkg;

  typedef enum logic [1:0] {
    TOK_EOS   = 2'd0,
    TOK_BEGIN = 2'd1,
    TOK_END   = 2'd2,
    TOK_OTHER = 2'd3
  } tok_code_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MB,
    S_ME,
    S_OTH
  } state_e;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
  localparam logic [7:0] CH_UPPER_A  = 8'h41;
  localparam logic [7:0] CH_UPPER_Z  = 8'h5A;
  localparam logic [7:0] CH_B        = 8'h62;
  localparam logic [7:0] CH_E        = 8'h65;

  localparam logic [2:0] BEGIN_LEN = 3'd5;
  localparam logic [2:0] END_LEN   = 3'd3;

  // Lowercase keyword character at position idx ("begin" or "end").
  function automatic logic [7:0] kw_char(input logic is_begin, input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    if (is_begin) begin
      case (idx)
        3'd0: c = 8'h62;
        3'd1: c = 8'h65;
        3'd2: c = 8'h67;
        3'd3: c = 8'h69;
        3'd4: c = 8'h6E;
        default: c = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0: c = 8'h65;
        3'd1: c = 8'h6E;
        3'd2: c = 8'h64;
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

  // Token code for a word that ends while the FSM is in state s with match index idx.
  function automatic tok_code_e word_code(input state_e s, input logic [2:0] idx);
    tok_code_e c;
    c = TOK_OTHER;
    if (s == S_MB && idx == BEGIN_LEN) c = TOK_BEGIN;
    if (s == S_ME && idx == END_LEN)   c = TOK_END;
    return c;
  endfunction

endpackage

// File: rtl/word_tokenizer_if.sv
// Byte-in / token-out bus of the word tokenizer. master = byte source and
// token consumer, slave = tokenizer.
interface word_tokenizer_if #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 16
) ();
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             tok_valid;
  logic [1:0]       tok_code;
  logic [LEN_W-1:0] tok_len;
  logic             tok_last;
  logic             tok_ready;
  logic [CNT_W-1:0] word_count;

  modport master (
    output in_valid, in_data, in_last, tok_ready,
    input  in_ready, tok_valid, tok_code, tok_len, tok_last, word_count
  );

  modport slave (
    input  in_valid, in_data, in_last, tok_ready,
    output in_ready, tok_valid, tok_code, tok_len, tok_last, word_count
  );
endinterface

// File: rtl/word_tokenizer_char_classifier.sv
// Combinational byte classifier: flags the space separator and folds ASCII
// uppercase letters to lowercase for keyword matching.
module char_classifier
  import word_tokenizer_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_space_o,
  output logic [7:0] lower_o
);
  always_comb begin
    is_space_o = (byte_i == CH_SPACE);
    lower_o    = byte_i;
    if (byte_i >= CH_UPPER_A && byte_i <= CH_UPPER_Z) lower_o = byte_i + CASE_OFFSET;
  end
endmodule

// File: rtl/word_tokenizer.sv
// Splits a byte stream into space-delimited words and emits one registered
// token (BEGIN/END/OTHER/EOS) per word with its saturating length.
module word_tokenizer
  import word_tokenizer_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  word_tokenizer_if.slave bus
);
  state_e           state_q, state_d, nxt_state;
  logic [2:0]       idx_q, idx_d, nxt_idx;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic             tok_valid_q;
  tok_code_e        tok_code_q;
  logic [LEN_W-1:0] tok_len_q;
  logic             tok_last_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_ready, accept, is_space;
  logic [7:0]       lower;
  logic             emit, emit_last;
  tok_code_e        emit_code;
  logic [LEN_W-1:0] emit_len;

  char_classifier u_cls (
    .byte_i    (bus.in_data),
    .is_space_o(is_space),
    .lower_o   (lower)
  );

  assign in_ready       = !tok_valid_q || bus.tok_ready;
  assign accept         = bus.in_valid && in_ready;
  assign bus.in_ready   = in_ready;
  assign bus.tok_valid  = tok_valid_q;
  assign bus.tok_code   = tok_code_q;
  assign bus.tok_len    = tok_len_q;
  assign bus.tok_last   = tok_last_q;
  assign bus.word_count = cnt_q;

  // Where a non-space byte would take the matcher; shared by the normal and in_last paths.
  always_comb begin
    nxt_state = state_q;
    nxt_idx   = idx_q;
    len_inc   = (len_q == '1) ? len_q : len_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        nxt_idx = 3'd1;
        if (lower == CH_B)      nxt_state = S_MB;
        else if (lower == CH_E) nxt_state = S_ME;
        else                    nxt_state = S_OTH;
      end
      S_MB: begin
        if (idx_q < BEGIN_LEN && lower == kw_char(1'b1, idx_q)) nxt_idx = idx_q + 3'd1;
        else nxt_state = S_OTH;
      end
      S_ME: begin
        if (idx_q < END_LEN && lower == kw_char(1'b0, idx_q)) nxt_idx = idx_q + 3'd1;
        else nxt_state = S_OTH;
      end
      default: nxt_state = S_OTH;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    emit      = 1'b0;
    emit_code = TOK_EOS;
    emit_len  = '0;
    emit_last = 1'b0;
    if (accept) begin
      if (is_space) begin
        state_d = S_IDLE;
        idx_d   = '0;
        len_d   = '0;
        if (state_q != S_IDLE) begin
          emit      = 1'b1;
          emit_code = word_code(state_q, idx_q);
          emit_len  = len_q;
          emit_last = bus.in_last;
        end else if (bus.in_last) begin
          emit      = 1'b1;
          emit_last = 1'b1;
        end
      end else if (bus.in_last) begin
        // Final byte joins the word first, so classify on the post-byte match state.
        emit      = 1'b1;
        emit_code = word_code(nxt_state, nxt_idx);
        emit_len  = len_inc;
        emit_last = 1'b1;
        state_d   = S_IDLE;
        idx_d     = '0;
        len_d     = '0;
      end else begin
        state_d = nxt_state;
        idx_d   = nxt_idx;
        len_d   = len_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok_valid_q <= 1'b0;
      tok_code_q  <= TOK_EOS;
      tok_len_q   <= '0;
      tok_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else if (emit) begin
      tok_valid_q <= 1'b1;
      tok_code_q  <= emit_code;
      tok_len_q   <= emit_len;
      tok_last_q  <= emit_last;
      if (emit_code != TOK_EOS && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end else if (bus.tok_ready) begin
      tok_valid_q <= 1'b0;
    end
  end

endmodule
